// File: rtl/treelut_pkg.sv
// treelut_pkg: derived widths, node-word field offsets and FSM states shared by the
// tree-ensemble walker and its argmax stage.
package treelut_pkg;

   // Bits needed to index v items, never less than one.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 32'd1) ? 32'd1 : $clog2(v);
   endfunction

   // Width of a class index.
   function automatic int unsigned cls_w(input int unsigned n_class);
      return clog2_min1(n_class);
   endfunction

   // Width of a feature index; values at or above N_FEAT are representable on purpose.
   function automatic int unsigned fidx_w(input int unsigned n_feat);
      return clog2_min1(n_feat);
   endfunction

   // Width of a tree-local child index.
   function automatic int unsigned child_w(input int unsigned nodes_per_tree);
      return clog2_min1(nodes_per_tree);
   endfunction

   // Width of a global node-memory address.
   function automatic int unsigned node_aw(input int unsigned n_trees,
                                           input int unsigned nodes_per_tree);
      return clog2_min1(n_trees * nodes_per_tree);
   endfunction

   // Node word: leaf flag on top, then feature index, true child, false child.
   function automatic int unsigned node_w(input int unsigned n_feat,
                                          input int unsigned nodes_per_tree,
                                          input int unsigned leaf_w);
      int unsigned internal_w;
      internal_w = 32'd1 + fidx_w(n_feat) + 32'd2 * child_w(nodes_per_tree);
      return (internal_w > (32'd1 + leaf_w)) ? internal_w : (32'd1 + leaf_w);
   endfunction

   // Class sum width: large enough that N_TREES maximal leaves cannot overflow.
   function automatic int unsigned sum_w(input int unsigned leaf_w,
                                         input int unsigned n_trees);
      return leaf_w + $clog2(n_trees);
   endfunction

   // Field offsets inside an internal node word.
   function automatic int unsigned false_lsb();
      return 32'd0;
   endfunction

   function automatic int unsigned true_lsb(input int unsigned cw);
      return cw;
   endfunction

   function automatic int unsigned feat_lsb(input int unsigned cw);
      return 32'd2 * cw;
   endfunction

   typedef enum logic [1:0] {
      StIdle,
      StWalk,
      StArgmax,
      StDone
   } state_e;

endpackage

// File: rtl/treelut_argmax.sv
// treelut_argmax: combinational index of the largest class sum; lowest index wins ties.
module treelut_argmax
   import treelut_pkg::*;
#(
   parameter int unsigned N_CLASS = 2,
   parameter int unsigned SUM_W   = 5,
   parameter int unsigned CLS_W   = cls_w(N_CLASS)
) (
   input  logic [N_CLASS*SUM_W-1:0] sums_i,
   output logic [CLS_W-1:0]         idx_o
);

   logic [SUM_W-1:0] best;

   // Strict greater-than keeps the earliest class on equal sums.
   always_comb begin
      best  = sums_i[SUM_W-1:0];
      idx_o = '0;
      for (int c = 1; c < int'(N_CLASS); c++) begin
         if (sums_i[c*SUM_W +: SUM_W] > best) begin
            best  = sums_i[c*SUM_W +: SUM_W];
            idx_o = CLS_W'(c);
         end
      end
   end

endmodule

// File: rtl/treelut_tree_walker.sv
// treelut_tree_walker: walks N_TREES binary decision trees one node per cycle over a
// latched feature vector, accumulates leaf votes per class and reports the argmax.
// Optional feature: define TREELUT_CLASS_SUMS_EN to expose the class sums on o_sums.
module treelut_tree_walker
   import treelut_pkg::*;
#(
   parameter int unsigned N_FEAT         = 186,
   parameter int unsigned N_TREES        = 4,
   parameter int unsigned N_CLASS        = 2,
   parameter int unsigned NODES_PER_TREE = 16,
   parameter int unsigned LEAF_W         = 3,
   parameter int unsigned MAX_DEPTH      = 8,
   localparam int unsigned CLS_W         = cls_w(N_CLASS),
   localparam int unsigned FIDX_W        = fidx_w(N_FEAT),
   localparam int unsigned CHILD_W       = child_w(NODES_PER_TREE),
   localparam int unsigned NODE_AW       = node_aw(N_TREES, NODES_PER_TREE),
   localparam int unsigned NODE_W        = node_w(N_FEAT, NODES_PER_TREE, LEAF_W),
   localparam int unsigned SUM_W         = sum_w(LEAF_W, N_TREES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [NODE_AW-1:0] cfg_addr,
   input  logic [NODE_W-1:0]  cfg_data,
   input  logic               i_valid,
   output logic               i_ready,
   input  logic [N_FEAT-1:0]  i,
   output logic               o_valid,
   input  logic               o_ready,
   output logic [CLS_W-1:0]   o,
   output logic               o_err
`ifdef TREELUT_CLASS_SUMS_EN
   ,
   output logic [N_CLASS*SUM_W-1:0] o_sums
`endif
);

   localparam int unsigned N_NODES = N_TREES * NODES_PER_TREE;
   localparam int unsigned TREE_W  = clog2_min1(N_TREES);
   localparam int unsigned DEPTH_W = clog2_min1(MAX_DEPTH + 1);
   localparam int unsigned F_LSB   = false_lsb();
   localparam int unsigned T_LSB   = true_lsb(CHILD_W);
   localparam int unsigned X_LSB   = feat_lsb(CHILD_W);

   logic [NODE_W-1:0]        mem_q [N_NODES];

   state_e                   state_q, state_d;
   logic [N_FEAT-1:0]        feat_q, feat_d;
   logic [TREE_W-1:0]        tree_q, tree_d;
   logic [CLS_W-1:0]         cls_q, cls_d;
   logic [CHILD_W-1:0]       node_q, node_d;
   logic [DEPTH_W-1:0]       depth_q, depth_d;
   logic [N_CLASS*SUM_W-1:0] sums_q, sums_d;
   logic                     err_q, err_d;
   logic [CLS_W-1:0]         o_q, o_d;
   logic                     o_err_q, o_err_d;
   logic                     o_valid_q, o_valid_d;
   logic                     i_ready_q, i_ready_d;

   logic [NODE_AW-1:0]       rd_addr;
   logic [NODE_W-1:0]        node_word;
   logic                     is_leaf;
   logic [FIDX_W-1:0]        feat_idx;
   logic                     feat_bit;
   logic [CHILD_W-1:0]       next_child;
   logic [LEAF_W-1:0]        leaf_val;
   logic [CLS_W-1:0]         argmax_idx;

   treelut_argmax #(
      .N_CLASS (N_CLASS),
      .SUM_W   (SUM_W),
      .CLS_W   (CLS_W)
   ) u_argmax (
      .sums_i (sums_q),
      .idx_o  (argmax_idx)
   );

   // Node memory: no reset, writable only while idle.
   always_ff @(posedge clk) begin
      if (cfg_we && (state_q == StIdle) && (32'(cfg_addr) < N_NODES)) begin
         mem_q[cfg_addr] <= cfg_data;
      end
   end

   // Fetch and decode the current node; out-of-range feature indices read as 0.
   always_comb begin
      rd_addr    = NODE_AW'(32'(tree_q) * NODES_PER_TREE + 32'(node_q));
      node_word  = mem_q[rd_addr];
      is_leaf    = node_word[NODE_W-1];
      feat_idx   = node_word[X_LSB +: FIDX_W];
      feat_bit   = 1'b0;
      if (32'(feat_idx) < N_FEAT) begin
         feat_bit = feat_q[feat_idx];
      end
      next_child = feat_bit ? node_word[T_LSB +: CHILD_W] : node_word[F_LSB +: CHILD_W];
   end

   // Next-state logic for the accept/walk/argmax/done sequence.
   always_comb begin
      state_d   = state_q;
      feat_d    = feat_q;
      tree_d    = tree_q;
      cls_d     = cls_q;
      node_d    = node_q;
      depth_d   = depth_q;
      sums_d    = sums_q;
      err_d     = err_q;
      o_d       = o_q;
      o_err_d   = o_err_q;
      o_valid_d = o_valid_q;
      i_ready_d = i_ready_q;
      leaf_val  = '0;

      unique case (state_q)
         StIdle: begin
            if (i_valid) begin
               feat_d    = i;
               tree_d    = '0;
               cls_d     = '0;
               node_d    = '0;
               depth_d   = '0;
               sums_d    = '0;
               err_d     = 1'b0;
               i_ready_d = 1'b0;
               state_d   = StWalk;
            end
         end
         StWalk: begin
            if (!is_leaf && (depth_q != DEPTH_W'(MAX_DEPTH))) begin
               node_d  = next_child;
               depth_d = depth_q + 1'b1;
            end else begin
               // A node still internal at the depth limit ends the tree with value 0.
               if (is_leaf) begin
                  leaf_val = node_word[LEAF_W-1:0];
               end else begin
                  err_d = 1'b1;
               end
               sums_d[32'(cls_q)*SUM_W +: SUM_W] =
                  sums_q[32'(cls_q)*SUM_W +: SUM_W] + SUM_W'(leaf_val);
               if (tree_q == TREE_W'(N_TREES - 1)) begin
                  state_d = StArgmax;
               end else begin
                  tree_d  = tree_q + 1'b1;
                  cls_d   = (cls_q == CLS_W'(N_CLASS - 1)) ? '0 : cls_q + 1'b1;
                  node_d  = '0;
                  depth_d = '0;
               end
            end
         end
         StArgmax: begin
            o_d       = argmax_idx;
            o_err_d   = err_q;
            o_valid_d = 1'b1;
            state_d   = StDone;
         end
         StDone: begin
            if (o_ready) begin
               o_valid_d = 1'b0;
               i_ready_d = 1'b1;
               state_d   = StIdle;
            end
         end
         default: begin
            state_d   = StIdle;
            o_valid_d = 1'b0;
            i_ready_d = 1'b1;
         end
      endcase
   end

   // FSM and datapath state; reset abandons any walk in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         feat_q    <= '0;
         tree_q    <= '0;
         cls_q     <= '0;
         node_q    <= '0;
         depth_q   <= '0;
         sums_q    <= '0;
         err_q     <= 1'b0;
         o_q       <= '0;
         o_err_q   <= 1'b0;
         o_valid_q <= 1'b0;
         i_ready_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         feat_q    <= feat_d;
         tree_q    <= tree_d;
         cls_q     <= cls_d;
         node_q    <= node_d;
         depth_q   <= depth_d;
         sums_q    <= sums_d;
         err_q     <= err_d;
         o_q       <= o_d;
         o_err_q   <= o_err_d;
         o_valid_q <= o_valid_d;
         i_ready_q <= i_ready_d;
      end
   end

   assign i_ready = i_ready_q;
   assign o_valid = o_valid_q;
   assign o       = o_q;
   assign o_err   = o_err_q;
`ifdef TREELUT_CLASS_SUMS_EN
   assign o_sums  = sums_q;
`endif

endmodule

// File: tb/tb_treelut_tree_walker.sv
// tb_treelut_tree_walker: directed and randomized checks of the tree walker against an
// algorithmic ensemble model kept in the bench.
module tb_treelut_tree_walker;

   localparam int unsigned N_FEAT    = 186;
   localparam int unsigned N_TREES   = 4;
   localparam int unsigned N_CLASS   = 2;
   localparam int unsigned NPT       = 16;
   localparam int unsigned LEAF_W    = 3;
   localparam int unsigned MAX_DEPTH = 8;
   localparam int unsigned N_NODES   = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [5:0]  cfg_addr = '0;
   logic [16:0] cfg_data = '0;
   logic        i_valid = 1'b0;
   logic        i_ready;
   logic [185:0] i = '0;
   logic        o_valid;
   logic        o_ready = 1'b0;
   logic [0:0]  o;
   logic        o_err;
`ifdef TREELUT_CLASS_SUMS_EN
   logic [9:0]  o_sums;
`endif

   logic [16:0] bm [N_NODES];
   int          exp_o;
   bit          exp_err;
   logic [9:0]  exp_sums;
   bit          chk_en = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;

   treelut_tree_walker #(
      .N_FEAT         (N_FEAT),
      .N_TREES        (N_TREES),
      .N_CLASS        (N_CLASS),
      .NODES_PER_TREE (NPT),
      .LEAF_W         (LEAF_W),
      .MAX_DEPTH      (MAX_DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .i        (i),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .o        (o),
      .o_err    (o_err)
`ifdef TREELUT_CLASS_SUMS_EN
      ,
      .o_sums   (o_sums)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [16:0] mk_int(input int f, input int t, input int fl);
      return {1'b0, 8'(f), 4'(t), 4'(fl)};
   endfunction

   function automatic logic [16:0] mk_leaf(input int v);
      return {1'b1, 13'd0, 3'(v)};
   endfunction

   // Ensemble evaluation straight from the tree rules.
   function automatic void model_run(input logic [185:0] v, output int cls, output bit err,
                                     output logic [9:0] sums, output int lat);
      int s [N_CLASS];
      int node, depth, val, f;
      logic [16:0] w;
      bit done;
      for (int c = 0; c < int'(N_CLASS); c++) s[c] = 0;
      err = 1'b0;
      lat = 1;
      for (int t = 0; t < int'(N_TREES); t++) begin
         node = 0;
         depth = 0;
         val = 0;
         done = 1'b0;
         while (!done) begin
            w = bm[t * int'(NPT) + node];
            if (w[16]) begin
               val = int'(w[2:0]);
               done = 1'b1;
            end else if (depth == int'(MAX_DEPTH)) begin
               val = 0;
               err = 1'b1;
               done = 1'b1;
            end else begin
               f = int'(w[15:8]);
               node = (f < int'(N_FEAT) && v[f]) ? int'(w[7:4]) : int'(w[3:0]);
               depth++;
            end
         end
         lat += depth + 1;
         s[t % int'(N_CLASS)] += val;
      end
      cls = 0;
      for (int c = 1; c < int'(N_CLASS); c++) if (s[c] > s[cls]) cls = c;
      sums = {5'(s[1]), 5'(s[0])};
   endfunction

   function automatic logic [16:0] rand_node(input int idx);
      int lo;
      if ($urandom_range(0, 9) < 4) return mk_leaf(int'($urandom_range(0, 7)));
      lo = (idx < 15) ? idx + 1 : 15;
      if ($urandom_range(0, 19) == 0) lo = 0;
      return mk_int(int'($urandom_range(0, 255)), int'($urandom_range(lo, 15)),
                    int'($urandom_range(lo, 15)));
   endfunction

   task automatic cfg_write(input int a, input logic [16:0] d);
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_addr = 6'(a);
      cfg_data = d;
      bm[a] = d;
      @(posedge clk);
      #1 cfg_we = 1'b0;
   endtask

   // mode 0: plain; 1: write attempted during the walk; 2: write in the accept cycle.
   task automatic send(input logic [185:0] v, input int hold, input int mode, input int waddr,
                       input logic [16:0] wdata, output int m_o, output bit m_err,
                       output logic [9:0] m_sums, output int m_lat);
      int lat;
      bit seen;
      @(negedge clk);
      if (mode == 2) begin
         cfg_we = 1'b1;
         cfg_addr = 6'(waddr);
         cfg_data = wdata;
         bm[waddr] = wdata;
      end
      model_run(v, m_o, m_err, m_sums, m_lat);
      exp_o = m_o;
      exp_err = m_err;
      exp_sums = m_sums;
      chk("i_ready_idle", 64'(i_ready), 64'd1);
      i = v;
      i_valid = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      cfg_we = 1'b0;
      if (mode == 1) begin
         cfg_we = 1'b1;
         cfg_addr = 6'(waddr);
         cfg_data = wdata;
      end
      chk_en = 1'b1;
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         cfg_we = 1'b0;
         seen = o_valid;
      end
      chk("latency", 64'(lat), 64'(m_lat));
      for (int h = 0; h < hold; h++) begin
         i = ~v;
         i_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk("hold_o_valid", 64'(o_valid), 64'd1);
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      o_ready = 1'b0;
      chk_en = 1'b0;
      chk("o_valid_drop", 64'(o_valid), 64'd0);
      chk("i_ready_back", 64'(i_ready), 64'd1);
   endtask

   // Result checker: whenever a result is presented it must match the model and hold.
   always @(negedge clk) begin
      if (chk_en && o_valid) begin
         chk("o", 64'(o), 64'(exp_o));
         chk("o_err", 64'(o_err), 64'(exp_err));
         chk("i_ready_busy", 64'(i_ready), 64'd0);
`ifdef TREELUT_CLASS_SUMS_EN
         chk("o_sums", 64'(o_sums), 64'(exp_sums));
`endif
      end
   end

   initial begin
      int mo, ml;
      bit me, seen;
      logic [9:0] ms;
      logic [185:0] v;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_o_valid", 64'(o_valid), 64'd0);
      chk("rst_o", 64'(o), 64'd0);
      chk("rst_o_err", 64'(o_err), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_i_ready", 64'(i_ready), 64'd1);

      for (int a = 0; a < int'(N_NODES); a++) cfg_write(a, mk_leaf(0));
      cfg_write(0, mk_int(86, 1, 2));
      cfg_write(1, mk_leaf(2));
      cfg_write(2, mk_leaf(5));

      // Tree 0 takes the false branch: class 0 gets 5.
      v = '0;
      send(v, 0, 0, 0, '0, mo, me, ms, ml);
      chk("a_o", 64'(mo), 64'd0);
      chk("a_sums", 64'(ms), 64'({5'd0, 5'd5}));
      chk("a_lat", 64'(ml), 64'd6);

      // True branch: class 0 gets 2.
      v[86] = 1'b1;
      send(v, 0, 0, 0, '0, mo, me, ms, ml);
      chk("b_o", 64'(mo), 64'd0);
      chk("b_sums", 64'(ms), 64'({5'd0, 5'd2}));

      // Tree 1 (class 1) leaf 3 beats 2.
      cfg_write(16, mk_leaf(3));
      send(v, 0, 0, 0, '0, mo, me, ms, ml);
      chk("c_o", 64'(mo), 64'd1);
      chk("c_sums", 64'(ms), 64'({5'd3, 5'd2}));

      // 1 vs 1 tie resolves to class 0.
      cfg_write(16, mk_leaf(1));
      cfg_write(1, mk_leaf(1));
      send(v, 0, 0, 0, '0, mo, me, ms, ml);
      chk("tie_o", 64'(mo), 64'd0);
      chk("tie_sums", 64'(ms), 64'({5'd1, 5'd1}));

      // Tree 2 loops on itself; result held back for 5 cycles.
      cfg_write(16, mk_leaf(3));
      cfg_write(32, mk_int(86, 0, 0));
      send(v, 5, 0, 0, '0, mo, me, ms, ml);
      chk("loop_o", 64'(mo), 64'd1);
      chk("loop_err", 64'(me), 64'd1);
      chk("loop_sums", 64'(ms), 64'({5'd3, 5'd1}));
      chk("loop_lat", 64'(ml), 64'd14);

      // Reset while tree 2 is being walked.
      @(negedge clk);
      i = v;
      i_valid = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_walk_o_valid", 64'(o_valid), 64'd0);
      chk("rst_walk_o", 64'(o), 64'd0);
      chk("rst_walk_o_err", 64'(o_err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (o_valid) seen = 1'b1;
      end
      chk("no_valid_after_rst", 64'(seen), 64'd0);
      chk("rst_walk_i_ready", 64'(i_ready), 64'd1);

      // Write in the accept cycle is seen by the walk; memory survived reset.
      send(v, 1, 2, 32, mk_leaf(4), mo, me, ms, ml);
      chk("same_cycle_o", 64'(mo), 64'd0);
      chk("same_cycle_sums", 64'(ms), 64'({5'd3, 5'd5}));
      chk("same_cycle_lat", 64'(ml), 64'd6);

      // Write during the walk must be dropped.
      send(v, 0, 1, 48, mk_leaf(7), mo, me, ms, ml);
      chk("busy_write_o", 64'(mo), 64'd0);

      for (int n = 0; n < 1000; n++) begin
         if (n % 50 == 0) begin
            for (int a = 0; a < int'(N_NODES); a++) cfg_write(a, rand_node(a % int'(NPT)));
         end
         for (int b = 0; b < int'(N_FEAT); b++) v[b] = 1'($urandom_range(0, 1));
         send(v, int'($urandom_range(0, 2)), 0, 0, '0, mo, me, ms, ml);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
